instruction_decoder: RTL

Decode stage feeding `control_unit`. It takes the raw RV32I word returned by instruction memory in stage si and produces the registered `microcode_s0` / `instruction_data_s0` pair that `control_unit` consumes in stage s0. It inserts bubbles on `block_inst` and on the first edge after reset. It also detects illegal encodings, recording them in a sticky flag with the offending word address.

---
 rtl/instruction_decoder.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/instruction_decoder.sv
// RV32I decode stage: turns the instruction-memory word into the registered
// control word consumed by control_unit, inserting bubbles and trapping illegal encodings.
module instruction_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] pc,
    input  logic [31:0] inst_in,
    input  logic        block_inst,
    output logic [31:0] microcode_s0,
    output logic [24:0] instruction_data_s0,
    output logic        illegal_inst,
    output logic [29:0] illegal_pc
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [1:0] A_PC    = 2'b01;
    localparam logic [1:0] B_REG   = 2'b00;
    localparam logic [1:0] B_IIMM  = 2'b01;
    localparam logic [1:0] B_SIMM  = 2'b10;
    localparam logic [1:0] B_UIMM  = 2'b11;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [2:0] BC_ALWAYS = 3'b111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = inst_in[6:0];
    assign funct3 = inst_in[14:12];
    assign funct7 = inst_in[31:25];

    // Decoded control fields
    logic       check_rs1;
    logic       check_rs2;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic       a_to_alu;
    logic       b_to_alu;
    logic [3:0] alu_op;
    logic [2:0] branch_cond;
    logic       mem_we;
    logic       alu_out_to_mem_addr;
    logic       jump_if_branch;
    logic       mem_in_use;
    logic       reg_we;
    logic       up_to_reg;
    logic       alu_out_to_reg;
    logic       ret_addr_to_reg;
    logic       mem_data_out;
    logic       dec_illegal;
    logic [31:0] decoded_word;

    always_comb begin
        check_rs1           = 1'b0;
        check_rs2           = 1'b0;
        a_sel               = 2'b00;
        b_sel               = B_REG;
        a_to_alu            = 1'b0;
        b_to_alu            = 1'b0;
        alu_op              = 4'b0000;
        branch_cond         = 3'b000;
        mem_we              = 1'b0;
        alu_out_to_mem_addr = 1'b0;
        jump_if_branch      = 1'b0;
        mem_in_use          = 1'b0;
        reg_we              = 1'b0;
        up_to_reg           = 1'b0;
        alu_out_to_reg      = 1'b0;
        ret_addr_to_reg     = 1'b0;
        mem_data_out        = 1'b0;
        dec_illegal         = 1'b0;

        case (opcode)
            OPC_LUI: begin
                reg_we    = 1'b1;
                up_to_reg = 1'b1;
            end
            OPC_AUIPC: begin
                a_sel          = A_PC;
                b_sel          = B_UIMM;
                a_to_alu       = 1'b1;
                b_to_alu       = 1'b1;
                reg_we         = 1'b1;
                alu_out_to_reg = 1'b1;
            end
            OPC_JAL: begin
                branch_cond     = BC_ALWAYS;
                jump_if_branch  = 1'b1;
                reg_we          = 1'b1;
                ret_addr_to_reg = 1'b1;
            end
            OPC_JALR: begin
                check_rs1       = 1'b1;
                branch_cond     = BC_ALWAYS;
                jump_if_branch  = 1'b1;
                reg_we          = 1'b1;
                ret_addr_to_reg = 1'b1;
                dec_illegal     = (funct3 != F3_ADD);
            end
            OPC_BRANCH: begin
                check_rs1      = 1'b1;
                check_rs2      = 1'b1;
                jump_if_branch = 1'b1;
                // Compress funct3 into the control unit's dense condition code
                case (funct3)
                    3'b000:  branch_cond = 3'b001;
                    3'b001:  branch_cond = 3'b010;
                    3'b100:  branch_cond = 3'b011;
                    3'b101:  branch_cond = 3'b100;
                    3'b110:  branch_cond = 3'b101;
                    3'b111:  branch_cond = 3'b110;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                check_rs1           = 1'b1;
                b_sel               = B_IIMM;
                a_to_alu            = 1'b1;
                b_to_alu            = 1'b1;
                alu_out_to_mem_addr = 1'b1;
                mem_in_use          = 1'b1;
                reg_we              = 1'b1;
                mem_data_out        = 1'b1;
                dec_illegal         = (funct3 != F3_WORD);
            end
            OPC_STORE: begin
                check_rs1           = 1'b1;
                check_rs2           = 1'b1;
                b_sel               = B_SIMM;
                a_to_alu            = 1'b1;
                b_to_alu            = 1'b1;
                alu_out_to_mem_addr = 1'b1;
                mem_in_use          = 1'b1;
                mem_we              = 1'b1;
                dec_illegal         = (funct3 != F3_WORD);
            end
            OPC_OP_IMM: begin
                check_rs1      = 1'b1;
                b_sel          = B_IIMM;
                a_to_alu       = 1'b1;
                b_to_alu       = 1'b1;
                reg_we         = 1'b1;
                alu_out_to_reg = 1'b1;
                alu_op         = {1'b0, funct3};
                // Only shifts constrain the upper bits; other forms carry immediate there
                if (funct3 == F3_SLL) begin
                    dec_illegal = (funct7 != F7_BASE);
                end else if (funct3 == F3_SR) begin
                    if (funct7 == F7_ALT) begin
                        alu_op[3] = 1'b1;
                    end else if (funct7 != F7_BASE) begin
                        dec_illegal = 1'b1;
                    end
                end
            end
            OPC_OP: begin
                check_rs1      = 1'b1;
                check_rs2      = 1'b1;
                b_sel          = B_REG;
                a_to_alu       = 1'b1;
                b_to_alu       = 1'b1;
                reg_we         = 1'b1;
                alu_out_to_reg = 1'b1;
                alu_op         = {1'b0, funct3};
                if (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)) begin
                    alu_op[3] = 1'b1;
                end else if (funct7 != F7_BASE) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_FENCE: begin
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign decoded_word = {8'h00, mem_data_out, ret_addr_to_reg, alu_out_to_reg, up_to_reg,
                           reg_we, mem_in_use, jump_if_branch, alu_out_to_mem_addr, mem_we,
                           branch_cond, alu_op, b_to_alu, a_to_alu, b_sel, a_sel,
                           check_rs2, check_rs1};

    logic [29:0] pc_si_q, pc_si_d;
    logic        warmup_q, warmup_d;
    logic [31:0] microcode_q, microcode_d;
    logic [24:0] inst_data_q, inst_data_d;
    logic        illegal_q, illegal_d;
    logic [29:0] illegal_pc_q, illegal_pc_d;

    always_comb begin
        pc_si_d      = pc;
        warmup_d     = 1'b0;
        inst_data_d  = inst_in[31:7];
        illegal_d    = illegal_q;
        illegal_pc_d = illegal_pc_q;
        microcode_d  = decoded_word;

        // A bubble also masks illegal detection: the word is not being issued
        if (warmup_q || block_inst) begin
            microcode_d = 32'h0;
        end else if (dec_illegal) begin
            microcode_d = 32'h0;
            if (!illegal_q) begin
                illegal_d    = 1'b1;
                illegal_pc_d = pc_si_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_si_q      <= '0;
            warmup_q     <= 1'b1;
            microcode_q  <= '0;
            inst_data_q  <= '0;
            illegal_q    <= 1'b0;
            illegal_pc_q <= '0;
        end else begin
            pc_si_q      <= pc_si_d;
            warmup_q     <= warmup_d;
            microcode_q  <= microcode_d;
            inst_data_q  <= inst_data_d;
            illegal_q    <= illegal_d;
            illegal_pc_q <= illegal_pc_d;
        end
    end

    assign microcode_s0        = microcode_q;
    assign instruction_data_s0 = inst_data_q;
    assign illegal_inst        = illegal_q;
    assign illegal_pc          = illegal_pc_q;

endmodule
